// File: rtl/instr_deserializer_if.sv
// Byte-stream input and assembled-instruction output of the instruction deserializer.
// The master side is the CPU byte source plus the request queues; the slave side is the deserializer.
interface instr_deserializer_if #(
    parameter int ADDRW   = 24,
    parameter int OPCODEW = 2
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               ready_aes;
    logic               ready_sha;
    logic               valid_out;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   key_addr;
    logic [ADDRW-1:0]   text_addr;
    logic [ADDRW-1:0]   dest_addr;
    logic               frame_err;

    modport master (
        output in_valid, in_data, ready_aes, ready_sha,
        input  in_ready, valid_out, opcode, key_addr, text_addr, dest_addr, frame_err
    );

    modport slave (
        input  in_valid, in_data, ready_aes, ready_sha,
        output in_ready, valid_out, opcode, key_addr, text_addr, dest_addr, frame_err
    );
endinterface

// File: rtl/instr_deserializer.sv
// Assembles header + three MSB-first addresses from a byte stream into one instruction
// and presents it to the AES or SHA request queue selected by opcode bit 0.
module instr_deserializer #(
    parameter int ADDRW   = 24,
    parameter int OPCODEW = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_deserializer_if.slave   bus
);
    localparam int BPF = ADDRW / 8;
    localparam int NB  = 1 + 3 * BPF;
    localparam int CW  = $clog2(NB);
    localparam int IW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

    state_t             state;
    logic [CW-1:0]      byte_cnt;
    logic [IW-1:0]      idle_cnt;
    logic [IW-1:0]      idle_next;
    logic [OPCODEW-1:0] op_sh;
    logic [ADDRW-1:0]   key_sh, text_sh, dest_sh;
    logic               rdy, vld, err;
    logic [OPCODEW-1:0] op;
    logic [ADDRW-1:0]   key, text, dest;
    logic               accept, sel_ready;

    assign accept    = bus.in_valid & rdy;
    assign sel_ready = op[0] ? bus.ready_sha : bus.ready_aes;
    assign idle_next = (idle_cnt == IW'(TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;

    assign bus.in_ready  = rdy;
    assign bus.valid_out = vld;
    assign bus.frame_err = err;
    assign bus.opcode    = op;
    assign bus.key_addr  = key;
    assign bus.text_addr = text;
    assign bus.dest_addr = dest;

    // Addresses assemble in shadow registers so the visible fields only change when a
    // complete frame is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
            op_sh    <= '0;
            key_sh   <= '0;
            text_sh  <= '0;
            dest_sh  <= '0;
            rdy      <= 1'b0;
            vld      <= 1'b0;
            err      <= 1'b0;
            op       <= '0;
            key      <= '0;
            text     <= '0;
            dest     <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        idle_cnt <= '0;
                        if ((bus.in_data >> OPCODEW) == 8'd0) begin
                            op_sh    <= bus.in_data[OPCODEW-1:0];
                            byte_cnt <= CW'(1);
                            state    <= COLLECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (byte_cnt <= CW'(BPF))
                            key_sh <= ADDRW'({key_sh, bus.in_data});
                        else if (byte_cnt <= CW'(2 * BPF))
                            text_sh <= ADDRW'({text_sh, bus.in_data});
                        else
                            dest_sh <= ADDRW'({dest_sh, bus.in_data});
                        if (byte_cnt == LAST) begin
                            // The final byte always belongs to dest; fold it in directly.
                            op       <= op_sh;
                            key      <= key_sh;
                            text     <= text_sh;
                            dest     <= ADDRW'({dest_sh, bus.in_data});
                            byte_cnt <= '0;
                            rdy      <= 1'b0;
                            vld      <= 1'b1;
                            state    <= PRESENT;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= idle_next;
                        if (idle_next == IW'(TIMEOUT)) begin
                            byte_cnt <= '0;
                            err      <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                PRESENT: begin
                    if (sel_ready) begin
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_deserializer.sv
// Self-checking bench for instr_deserializer: directed scenarios plus a randomized
// stream checked against a frame-level reference model.
module tb_instr_deserializer;
    localparam int ADDRW   = 24;
    localparam int OPCODEW = 2;
    localparam int TIMEOUT = 255;
    localparam int BPF     = ADDRW / 8;
    localparam int NB      = 1 + 3 * BPF;
    localparam int NFR     = 50;

    typedef logic [7:0] frame_t [NB];

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   vcount = 0;
    int   ecount = 0;

    always #5 clk = ~clk;

    instr_deserializer_if #(.ADDRW(ADDRW), .OPCODEW(OPCODEW)) bus ();

    instr_deserializer #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Counts presented cycles and error pulses; the two must never coincide.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.valid_out === 1'b1) vcount++;
            if (bus.frame_err === 1'b1) ecount++;
            tests++;
            if ((bus.valid_out & bus.frame_err) !== 1'b0) begin
                fails++;
                $display("FAIL err_with_valid: valid_out=%b frame_err=%b, required not both 1",
                         bus.valid_out, bus.frame_err);
            end
        end
    end

    function automatic frame_t make_frame(input logic [7:0] hdr, input logic [ADDRW-1:0] k,
                                          input logic [ADDRW-1:0] t, input logic [ADDRW-1:0] d);
        frame_t f;
        logic [3*ADDRW-1:0] all;
        all  = {k, t, d};
        f[0] = hdr;
        for (int i = 0; i < 3 * BPF; i++) f[i+1] = all[3*ADDRW-1-8*i -: 8];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.ready_aes = 1'b0;
        bus.ready_sha = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.valid_out, bus.frame_err} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: valid/err=%b, required 00", {bus.valid_out, bus.frame_err});
        end
        tests++;
        if ({bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr} !== '0) begin
            fails++;
            $display("FAIL reset_fields: op=%h key=%h text=%h dest=%h, required all 0",
                     bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        frame_t f;
        int v0;
        bus.ready_aes = 1'b1;
        bus.ready_sha = 1'b0;
        v0 = vcount;
        f = make_frame(8'h00, 24'h112233, 24'h445566, 24'h778899);
        send_frame(f, 0, NB);
        tests++;
        if ({bus.valid_out, bus.in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL basic_present: valid/in_ready=%b, required 10", {bus.valid_out, bus.in_ready});
        end
        tests++;
        if ({bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr} !== {2'b00, 24'h112233, 24'h445566, 24'h778899}) begin
            fails++;
            $display("FAIL basic_fields: op=%h key=%h text=%h dest=%h, required 0 112233 445566 778899",
                     bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr);
        end
        tick();
        tests++;
        if ({bus.valid_out, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL basic_after_xfer: valid/in_ready=%b, required 01", {bus.valid_out, bus.in_ready});
        end
        tests++;
        if (bus.key_addr !== 24'h112233) begin
            fails++;
            $display("FAIL basic_hold: key_addr=%h, required 112233", bus.key_addr);
        end
        repeat (3) tick();
        tests++;
        if (vcount - v0 !== 1) begin
            fails++;
            $display("FAIL basic_one_cycle: valid cycles=%0d, required 1", vcount - v0);
        end
    endtask

    task automatic test_backpressure();
        frame_t f;
        logic [ADDRW-1:0] k, t, d;
        k = ADDRW'($urandom);
        t = ADDRW'($urandom);
        d = ADDRW'($urandom);
        bus.ready_aes = 1'b1;
        bus.ready_sha = 1'b0;
        f = make_frame(8'h01, k, t, d);
        send_frame(f, 0, NB);
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({bus.valid_out, bus.in_ready} !== 2'b10 ||
                {bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr} !== {2'b01, k, t, d}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: valid=%b rdy=%b op=%h key=%h text=%h dest=%h, required 1 0 1 %h %h %h",
                         i, bus.valid_out, bus.in_ready, bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr, k, t, d);
            end
            tick();
        end
        bus.ready_sha = 1'b1;
        tests++;
        if (bus.valid_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_before_ready: valid_out=%b, required 1", bus.valid_out);
        end
        tick();
        tests++;
        if ({bus.valid_out, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_xfer: valid/in_ready=%b, required 01", {bus.valid_out, bus.in_ready});
        end
        bus.ready_sha = 1'b0;
    endtask

    task automatic test_bad_header();
        frame_t f;
        logic [ADDRW-1:0] k, t, d;
        int e0;
        e0 = ecount;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h04;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if ({bus.frame_err, bus.in_ready, bus.valid_out} !== 3'b110) begin
            fails++;
            $display("FAIL badhdr_pulse: err/rdy/valid=%b, required 110", {bus.frame_err, bus.in_ready, bus.valid_out});
        end
        tick();
        tests++;
        if (bus.frame_err !== 1'b0 || ecount - e0 !== 1) begin
            fails++;
            $display("FAIL badhdr_once: frame_err=%b pulses=%0d, required 0 and 1", bus.frame_err, ecount - e0);
        end
        k = ADDRW'($urandom);
        t = ADDRW'($urandom);
        d = ADDRW'($urandom);
        bus.ready_aes = 1'b1;
        f = make_frame(8'h02, k, t, d);
        send_frame(f, 0, NB);
        tests++;
        if ({bus.valid_out, bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr} !== {1'b1, 2'b10, k, t, d}) begin
            fails++;
            $display("FAIL badhdr_next: valid=%b op=%h key=%h text=%h dest=%h, required 1 2 %h %h %h",
                     bus.valid_out, bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr, k, t, d);
        end
        tick();
    endtask

    task automatic test_timeout();
        frame_t f;
        logic [ADDRW-1:0] k, t, d;
        int e0, first;
        e0 = ecount;
        first = -1;
        bus.ready_aes = 1'b1;
        f = make_frame(8'h00, 24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3);
        send_frame(f, 0, 4);
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            tick();
            if (bus.frame_err === 1'b1 && first < 0) first = i;
        end
        tests++;
        if (first !== TIMEOUT || ecount - e0 !== 1) begin
            fails++;
            $display("FAIL timeout_pulse: at idle cycle %0d, pulses %0d, required %0d and 1", first, ecount - e0, TIMEOUT);
        end
        k = ADDRW'($urandom);
        t = ADDRW'($urandom);
        d = ADDRW'($urandom);
        f = make_frame(8'h00, k, t, d);
        send_frame(f, 0, NB);
        tests++;
        if ({bus.valid_out, bus.key_addr, bus.text_addr, bus.dest_addr} !== {1'b1, k, t, d}) begin
            fails++;
            $display("FAIL timeout_next: valid=%b key=%h text=%h dest=%h, required 1 %h %h %h",
                     bus.valid_out, bus.key_addr, bus.text_addr, bus.dest_addr, k, t, d);
        end
        tick();
        // One idle cycle short of the limit must not discard the frame.
        e0 = ecount;
        f = make_frame(8'h00, k ^ 24'hFFFFFF, t, d);
        send_frame(f, 0, 3);
        repeat (TIMEOUT - 1) tick();
        send_frame(f, 3, NB);
        tests++;
        if (bus.valid_out !== 1'b1 || bus.key_addr !== (k ^ 24'hFFFFFF) || ecount !== e0) begin
            fails++;
            $display("FAIL timeout_edge: valid=%b key=%h pulses=%0d, required 1 %h 0",
                     bus.valid_out, bus.key_addr, ecount - e0, k ^ 24'hFFFFFF);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        frame_t f;
        logic [ADDRW-1:0] k, t, d;
        int v0, e0;
        v0 = vcount;
        e0 = ecount;
        bus.ready_aes = 1'b1;
        f = make_frame(8'h00, 24'h0BAD01, 24'h0BAD02, 24'h0BAD03);
        send_frame(f, 0, 5);
        rst_n = 1'b0;
        #2;
        tests++;
        if ({bus.valid_out, bus.frame_err} !== 2'b00 || bus.key_addr !== '0) begin
            fails++;
            $display("FAIL rst_async: valid=%b err=%b key=%h, required 0 0 0", bus.valid_out, bus.frame_err, bus.key_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        k = ADDRW'($urandom);
        t = ADDRW'($urandom);
        d = ADDRW'($urandom);
        f = make_frame(8'h00, k, t, d);
        send_frame(f, 0, NB);
        tests++;
        if ({bus.valid_out, bus.key_addr, bus.text_addr, bus.dest_addr} !== {1'b1, k, t, d}) begin
            fails++;
            $display("FAIL rst_second: valid=%b key=%h text=%h dest=%h, required 1 %h %h %h",
                     bus.valid_out, bus.key_addr, bus.text_addr, bus.dest_addr, k, t, d);
        end
        repeat (3) tick();
        tests++;
        if (vcount - v0 !== 1 || ecount !== e0) begin
            fails++;
            $display("FAIL rst_counts: valid cycles=%0d err pulses=%0d, required 1 0", vcount - v0, ecount - e0);
        end
        // Reset while presenting drops the instruction.
        bus.ready_aes = 1'b0;
        send_frame(f, 0, NB);
        rst_n = 1'b0;
        #2;
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++;
            $display("FAIL rst_present: valid_out=%b, required 0", bus.valid_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ready_aes = 1'b1;
        repeat (3) tick();
        tests++;
        if ({bus.valid_out, bus.in_ready, bus.frame_err} !== 3'b010) begin
            fails++;
            $display("FAIL rst_present_after: valid/rdy/err=%b, required 010", {bus.valid_out, bus.in_ready, bus.frame_err});
        end
    endtask

    task automatic test_random();
        frame_t           frames [NFR];
        logic [1:0]       ops    [NFR];
        logic [ADDRW-1:0] keys   [NFR];
        logic [ADDRW-1:0] texts  [NFR];
        logic [ADDRW-1:0] dests  [NFR];
        int  sent, done, xfer, cyc;
        logic exp_v, exp_r, bad;
        for (int i = 0; i < NFR; i++) begin
            ops[i]   = 2'($urandom_range(0, 3));
            keys[i]  = ADDRW'($urandom);
            texts[i] = ADDRW'($urandom);
            dests[i] = ADDRW'($urandom);
            frames[i] = make_frame({6'd0, ops[i]}, keys[i], texts[i], dests[i]);
        end
        sent = 0;
        done = 0;
        xfer = 0;
        cyc  = 0;
        bad  = 1'b0;
        while (xfer < NFR && cyc < 20000 && !bad) begin
            exp_v = (done > xfer);
            exp_r = !exp_v;
            tests++;
            if (bus.valid_out !== exp_v || bus.in_ready !== exp_r) begin
                fails++;
                bad = 1'b1;
                $display("FAIL rand_hs cyc %0d: valid=%b rdy=%b, required %b %b", cyc, bus.valid_out, bus.in_ready, exp_v, exp_r);
            end
            if (exp_v) begin
                tests++;
                if ({bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr} !== {ops[xfer], keys[xfer], texts[xfer], dests[xfer]}) begin
                    fails++;
                    bad = 1'b1;
                    $display("FAIL rand_fields frame %0d: op=%h key=%h text=%h dest=%h, required %h %h %h %h",
                             xfer, bus.opcode, bus.key_addr, bus.text_addr, bus.dest_addr,
                             ops[xfer], keys[xfer], texts[xfer], dests[xfer]);
                end
            end
            bus.in_valid  = (sent < NFR * NB) && ($urandom_range(0, 1) == 1);
            bus.in_data   = (sent < NFR * NB) ? frames[sent / NB][sent % NB] : 8'h00;
            bus.ready_aes = 1'($urandom_range(0, 1));
            bus.ready_sha = 1'($urandom_range(0, 1));
            tick();
            if (bus.in_valid && exp_r) begin
                sent++;
                if (sent % NB == 0) done++;
            end
            if (exp_v && (ops[xfer][0] ? bus.ready_sha : bus.ready_aes)) xfer++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (xfer !== NFR) begin
            fails++;
            $display("FAIL rand_complete: transferred %0d frames in %0d cycles, required %0d", xfer, cyc, NFR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_header();
        test_timeout();
        test_reset_midframe();
        test_random();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
